// File: rtl/minsoc_ram_arbiter.sv
// minsoc_ram_arbiter
// Shares the on-chip RAM's single Wishbone slave port between two masters:
// master 0 is the CPU instruction bus and master 1 is the CPU data/debug bus.
// Ownership is granted round-robin and held for as long as the owner keeps
// CYC asserted. A per-transfer watchdog ends any strobed access that the RAM
// does not terminate within TIMEOUT cycles, so that access cannot hang the bus.
//
// Handshake: the owning master's CYC&STB form the request ("valid"). A
// transfer completes in the cycle in which ack or err is high ("ready").
// Ack and err travel back to the owner combinationally, with no added
// latency. A master that does not own the port always sees ack = err = 0.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   m0_* / m1_* (inputs)      master requests: dat, adr, sel, we, cyc, stb
//   m0_dat_o / m1_dat_o       read data; both always carry s_dat_i
//   m0_ack_o .. m1_err_o      terminations; only the owner sees them
//   s_dat_o .. s_stb_o        request muxed to the RAM (all 0 when idle)
//   s_dat_i, s_ack_i, s_err_i RAM response
//   gnt_o                     one-hot owner {m1,m0}, 2'b00 = idle (FSM state)
module minsoc_ram_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] m0_dat_i,
  input  logic [31:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_dat_i,
  input  logic [31:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_dat_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  output logic [1:0]  gnt_o
);

  // The encoding is the one-hot grant itself, so gnt_o is the state register.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_gnt;   // 0: master 0 granted most recently, 1: master 1
  logic [CNT_W-1:0] wd_cnt;
  logic             wd_err;
  logic             cyc_mux;
  logic             stb_mux;

  // State register; last_gnt is updated on every entry into an OWN state.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        if (state_nxt == OWN0) begin
          last_gnt <= 1'b0;
        end else if (state_nxt == OWN1) begin
          last_gnt <= 1'b1;
        end
      end
    end
  end

  // Next-state logic. There is no pre-emption: the owner keeps the port until it
  // drops CYC. Handover to a waiting master happens directly, with no idle cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_nxt = last_gnt ? OWN0 : OWN1;
        end else if (m0_cyc_i) begin
          state_nxt = OWN0;
        end else if (m1_cyc_i) begin
          state_nxt = OWN1;
        end
      end
      OWN0: begin
        if (!m0_cyc_i) begin
          state_nxt = m1_cyc_i ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          state_nxt = m0_cyc_i ? OWN0 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: the slave mux, driven purely from the state register.
  always_comb begin
    cyc_mux = 1'b0;
    stb_mux = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = 4'h0;
    s_adr_o = 32'h0;
    s_dat_o = 32'h0;
    case (state)
      OWN0: begin
        cyc_mux = m0_cyc_i;
        stb_mux = m0_stb_i;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
      end
      OWN1: begin
        cyc_mux = m1_cyc_i;
        stb_mux = m1_stb_i;
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
      end
      default: ;
    endcase
  end

  // The watchdog fires on the cycle in which the count reaches TIMEOUT. Gating
  // with ~s_ack_i means a genuine ack in that cycle takes priority.
  assign wd_err = (TIMEOUT != 0) && (wd_cnt == CNT_W'(TIMEOUT)) &&
                  cyc_mux && stb_mux && !s_ack_i;

  // STB is withheld while the watchdog fires, so the RAM cannot complete an
  // access that the master has already seen end with err.
  assign s_cyc_o = cyc_mux;
  assign s_stb_o = stb_mux & ~wd_err;

  // The count restarts whenever there is no live strobe. A fired watchdog
  // drops s_stb_o, so it also clears the count on the following edge.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || (state_nxt != state) || s_ack_i || s_err_i ||
        !(s_cyc_o && s_stb_o)) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i & (state == OWN0);
  assign m1_ack_o = s_ack_i & (state == OWN1);
  assign m0_err_o = (s_err_i | wd_err) & (state == OWN0);
  assign m1_err_o = (s_err_i | wd_err) & (state == OWN1);
  assign gnt_o    = state;

endmodule

// File: tb/tb_minsoc_ram_arbiter.sv
module tb_minsoc_ram_arbiter;

  localparam int TMO = 5;

  // ---------------- clock / reset / signals ----------------
  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic [31:0] m0_dat_i, m0_adr_i, m1_dat_i, m1_adr_i, s_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
  logic        s_ack_i, s_err_i;

  logic [31:0] m0_dat_o, m1_dat_o, s_dat_o, s_adr_o;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, s_we_o, s_cyc_o, s_stb_o;
  logic [3:0]  s_sel_o;
  logic [1:0]  gnt_o;

  logic [31:0] nw_m0_dat_o, nw_m1_dat_o, nw_s_dat_o, nw_s_adr_o;
  logic        nw_m0_ack_o, nw_m1_ack_o, nw_m0_err_o, nw_m1_err_o;
  logic        nw_s_we_o, nw_s_cyc_o, nw_s_stb_o;
  logic [3:0]  nw_s_sel_o;
  logic [1:0]  nw_gnt_o;

  always #5 wb_clk_i = ~wb_clk_i;

  minsoc_ram_arbiter #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_dat_i(m0_dat_i), .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_dat_i(m1_dat_i), .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_dat_o(s_dat_o), .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .gnt_o(gnt_o)
  );

  // Same stimulus, watchdog disabled.
  minsoc_ram_arbiter #(.TIMEOUT(0), .CNT_W(8)) dut_nowd (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_dat_i(m0_dat_i), .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(nw_m0_dat_o), .m0_ack_o(nw_m0_ack_o),
    .m0_err_o(nw_m0_err_o),
    .m1_dat_i(m1_dat_i), .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(nw_m1_dat_o), .m1_ack_o(nw_m1_ack_o),
    .m1_err_o(nw_m1_err_o),
    .s_dat_o(nw_s_dat_o), .s_adr_o(nw_s_adr_o), .s_sel_o(nw_s_sel_o), .s_we_o(nw_s_we_o),
    .s_cyc_o(nw_s_cyc_o), .s_stb_o(nw_s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .gnt_o(nw_gnt_o)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the port (0 none, 1 = m0, 2 = m1), who was
  // served most recently, and how long the current strobe has been waiting.
  int own_m, last_m, wait_m;

  // One clock cycle: check outputs against the model at the falling edge,
  // work out the model's next state, then move past the rising edge.
  task automatic step();
    logic c, s, w, tmo, stb_out;
    logic [3:0] sl;
    logic [31:0] a, d;
    logic [1:0] g;
    int own_n, last_n, wait_n;
    @(negedge wb_clk_i);
    c = 1'b0; s = 1'b0; w = 1'b0; sl = 4'h0; a = 32'h0; d = 32'h0;
    if (own_m == 1) begin
      c = m0_cyc_i; s = m0_stb_i; w = m0_we_i; sl = m0_sel_i; a = m0_adr_i; d = m0_dat_i;
    end else if (own_m == 2) begin
      c = m1_cyc_i; s = m1_stb_i; w = m1_we_i; sl = m1_sel_i; a = m1_adr_i; d = m1_dat_i;
    end
    tmo     = (wait_m == TMO) && c && s && !s_ack_i;
    stb_out = s && !tmo;
    g       = (own_m == 1) ? 2'b01 : (own_m == 2) ? 2'b10 : 2'b00;

    chk("gnt",    32'(gnt_o),    32'(g));
    chk("s_cyc",  32'(s_cyc_o),  32'(c));
    chk("s_stb",  32'(s_stb_o),  32'(stb_out));
    chk("s_we",   32'(s_we_o),   32'(w));
    chk("s_sel",  32'(s_sel_o),  32'(sl));
    chk("s_adr",  s_adr_o,       a);
    chk("s_dat",  s_dat_o,       d);
    chk("m0_ack", 32'(m0_ack_o), 32'(s_ack_i && own_m == 1));
    chk("m1_ack", 32'(m1_ack_o), 32'(s_ack_i && own_m == 2));
    chk("m0_err", 32'(m0_err_o), 32'((s_err_i || tmo) && own_m == 1));
    chk("m1_err", 32'(m1_err_o), 32'((s_err_i || tmo) && own_m == 2));
    chk("m0_dat", m0_dat_o,      s_dat_i);
    chk("m1_dat", m1_dat_o,      s_dat_i);
    chk("nw_gnt",    32'(nw_gnt_o),    32'(g));
    chk("nw_s_stb",  32'(nw_s_stb_o),  32'(s));
    chk("nw_m0_err", 32'(nw_m0_err_o), 32'(s_err_i && own_m == 1));
    chk("nw_m1_err", 32'(nw_m1_err_o), 32'(s_err_i && own_m == 2));

    if (wb_rst_i) begin
      own_n = 0; last_n = 2; wait_n = 0;
    end else begin
      // Owner keeps the port while it holds CYC; otherwise any requester may
      // take it, and a tie goes to whoever was not served last.
      if (own_m != 0 && c)            own_n = own_m;
      else if (m0_cyc_i && m1_cyc_i)  own_n = 3 - last_m;
      else if (m0_cyc_i)              own_n = 1;
      else if (m1_cyc_i)              own_n = 2;
      else                            own_n = 0;
      last_n = (own_n != 0) ? own_n : last_m;
      if (own_n != own_m || s_ack_i || s_err_i || !(c && stb_out)) wait_n = 0;
      else wait_n = (wait_m + 1) % 256;
    end
    @(posedge wb_clk_i);
    #1;
    own_m = own_n; last_m = last_n; wait_m = wait_n;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic c0, s0, c1, s1, ack, err);
    m0_cyc_i = c0; m0_stb_i = s0; m1_cyc_i = c1; m1_stb_i = s1;
    s_ack_i = ack; s_err_i = err;
  endtask

  task automatic scramble();
    m0_dat_i = $urandom; m0_adr_i = $urandom; m0_sel_i = 4'($urandom_range(0, 15));
    m1_dat_i = $urandom; m1_adr_i = $urandom; m1_sel_i = 4'($urandom_range(0, 15));
    m0_we_i  = 1'($urandom_range(0, 1));
    m1_we_i  = 1'($urandom_range(0, 1));
    s_dat_i  = $urandom;
  endtask

  task automatic go_idle();
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int b0, b1;
    logic dead;
    wb_rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    scramble();
    repeat (3) @(posedge wb_clk_i);
    #1;
    own_m = 0; last_m = 2; wait_m = 0;

    // Reset state, checked with reset still asserted.
    step();
    #2;
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_cyc", 32'(s_cyc_o), 32'h0);
    wb_rst_i = 1'b0;

    // Tie straight after reset: m0, m1, m0, m1 with no idle gap.
    drive(1, 1, 1, 1, 0, 0);
    step();
    for (int k = 0; k < 4; k++) begin
      logic [1:0] want;
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
      s_ack_i = 1'b1;
      #2;
      chk("tie_gnt", 32'(gnt_o), 32'(want));
      step();
      s_ack_i = 1'b0;
      if (want == 2'b01) begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; end
      else begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; end
      step();
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    end
    go_idle();

    // Single read by m0.
    m0_adr_i = 32'h0000_0010;
    m0_we_i  = 1'b0;
    drive(1, 1, 0, 0, 0, 0);
    #2;
    chk("rd_gnt_lat", 32'(gnt_o), 32'h0);
    step();
    s_dat_i = 32'hDEAD_BEEF;
    s_ack_i = 1'b1;
    #2;
    chk("rd_gnt", 32'(gnt_o), 32'h1);
    chk("rd_adr", s_adr_o, 32'h0000_0010);
    chk("rd_ack", 32'(m0_ack_o), 32'h1);
    chk("rd_dat", m0_dat_o, 32'hDEAD_BEEF);
    chk("rd_m1_ack", 32'(m1_ack_o), 32'h0);
    step();
    go_idle();

    // Lock: m1 keeps CYC across 4 writes while m0 waits.
    m1_we_i = 1'b1;
    drive(0, 0, 1, 1, 0, 0);
    step();
    drive(1, 1, 1, 1, 1, 0);
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("lock_gnt", 32'(gnt_o), 32'h2);
      chk("lock_m0_ack", 32'(m0_ack_o), 32'h0);
      chk("lock_m1_ack", 32'(m1_ack_o), 32'h1);
      step();
    end
    drive(1, 1, 0, 0, 0, 0);
    #2;
    chk("lock_hold", 32'(gnt_o), 32'h2);
    step();
    #2;
    chk("lock_hand", 32'(gnt_o), 32'h1);
    go_idle();

    // Watchdog: RAM never acks; err in the 6th and 12th strobe cycles.
    drive(1, 1, 0, 0, 0, 0);
    step();
    for (int i = 1; i <= 12; i++) begin
      #2;
      chk("wd_err", 32'(m0_err_o), 32'(i == 6 || i == 12));
      chk("wd_stb", 32'(s_stb_o), 32'(!(i == 6 || i == 12)));
      chk("nowd_err", 32'(nw_m0_err_o), 32'h0);
      step();
    end
    go_idle();

    // Slave error while m1 owns.
    drive(0, 0, 1, 1, 0, 0);
    step();
    drive(1, 1, 1, 1, 0, 1);
    #2;
    chk("serr_m1", 32'(m1_err_o), 32'h1);
    chk("serr_m0", 32'(m0_err_o), 32'h0);
    step();
    go_idle();

    // Reset in the middle of an m0 write burst.
    m0_we_i = 1'b1;
    drive(1, 1, 0, 0, 0, 0);
    step();
    step();
    wb_rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    step();
    wb_rst_i = 1'b0;
    s_ack_i  = 1'b1;
    #2;
    chk("mrst_gnt", 32'(gnt_o), 32'h0);
    chk("mrst_cyc", 32'(s_cyc_o), 32'h0);
    chk("mrst_ack", 32'(m0_ack_o), 32'h0);
    step();
    drive(1, 1, 1, 1, 0, 0);
    step();
    #2;
    chk("mrst_tie", 32'(gnt_o), 32'h1);
    go_idle();

    // Random traffic: bursts, random acks, rare errors, dead-RAM stretches, resets.
    b0 = 0; b1 = 0; dead = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 150 == 0) dead = ($urandom_range(0, 2) == 0);
      scramble();
      if (b0 == 0 && $urandom_range(0, 3) == 0) b0 = $urandom_range(1, 8);
      if (b1 == 0 && $urandom_range(0, 3) == 0) b1 = $urandom_range(1, 8);
      m0_cyc_i = (b0 != 0);
      m1_cyc_i = (b1 != 0);
      m0_stb_i = ($urandom_range(0, 3) != 0) && (b0 != 0 || $urandom_range(0, 7) == 0);
      m1_stb_i = ($urandom_range(0, 3) != 0) && (b1 != 0 || $urandom_range(0, 7) == 0);
      if (b0 != 0) b0--;
      if (b1 != 0) b1--;
      s_ack_i  = !dead && ($urandom_range(0, 2) == 0);
      s_err_i  = ($urandom_range(0, 19) == 0);
      wb_rst_i = ($urandom_range(0, 299) == 0);
      step();
    end
    wb_rst_i = 1'b0;
    go_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
